// File: rtl/banco_write_arbiter.sv
// banco_write_arbiter: two-requester round-robin write-port arbiter for the
// 32x32 register bank. Grants at most one write beat per cycle, registers it,
// and drives the bank write port for exactly one cycle per accepted beat.
//
// Optional feature macro: BANCO_ZERO_GUARD_EN
//   defined   -> beats targeting r0 are consumed but never written
//   undefined -> r0 is written like any other register
//
// Handshake: a beat transfers on a rising edge where reqN_valid & reqN_ready
// are both 1. Ready is combinational from the valids, hold and last_grant, is
// never high while hold=1, and at most one ready is high per cycle. A
// requester keeps rg/data stable from raising valid until its beat transfers.
//
// The only arbitration state is last_grant, exported directly as a port so it
// can be observed and checked.
module banco_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [4:0]       req0_rg,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_rg,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic [4:0]       WriteRg,
  output logic [31:0]      WriteData,
  output logic             RegWrite,
  output logic             last_grant,
  output logic [CNT_W-1:0] wr_count
);

  logic        accept;
  logic [4:0]  sel_rg;
  logic [31:0] sel_data;
  logic        do_write;

  // Round-robin ready generation: on a tie the requester that did not win last goes.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = ~last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Winning beat selection and decision whether it reaches the bank.
  always_comb begin
    accept   = req0_ready | req1_ready;
    sel_rg   = req1_ready ? req1_rg   : req0_rg;
    sel_data = req1_ready ? req1_data : req0_data;
`ifdef BANCO_ZERO_GUARD_EN
    do_write = accept && (sel_rg != 5'd0);
`else
    do_write = accept;
`endif
  end

  // Output stage: one-cycle write pulse with the registered beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteRg   <= 5'd0;
      WriteData <= 32'd0;
    end else begin
      RegWrite <= do_write;
      if (do_write) begin
        WriteRg   <= sel_rg;
        WriteData <= sel_data;
      end
    end
  end

  // Arbitration state: remembers the most recent winner; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= req1_ready;
    end
  end

  // Count issued write pulses, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (RegWrite) begin
      wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: doc/banco_write_arbiter.md
# banco_write_arbiter

Two-requester write-port arbiter for the 32x32 register bank. Two writeback sources (e.g. ALU result path and memory-load path) present register writes over valid/ready handshakes. The arbiter grants one per cycle in round-robin order, registers the winning beat, and drives the bank's single write port (`WriteRg`, `WriteData`, `RegWrite`) for exactly one cycle per accepted beat. A downstream `hold` input lets the pipeline freeze new grants.

## Interface
Parameters:
- `CNT_W`, 16: width of the accepted-write counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `hold`  in  1: when 1, no grant is issued this cycle.
- `req0_valid`  in  1: requester 0 has a write beat.
- `req0_rg`  in  5: requester 0 destination register.
- `req0_data`  in  32: requester 0 write data.
- `req0_ready`  out  1: requester 0 beat accepted this cycle.
- `req1_valid`, `req1_rg`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `WriteRg`  out  5: to bank write address.
- `WriteData`  out  32: to bank write data.
- `RegWrite`  out  1: to bank write enable, one-cycle pulse.
- `last_grant`  out  1: index of the most recent granted requester.
- `wr_count`  out  CNT_W: number of `RegWrite` pulses issued, modulo 2^CNT_W.

## Operation
- Accept condition: a beat is accepted when `reqN_valid & reqN_ready` is true at a rising edge.
- `reqN_ready` is combinational from the valids, `hold` and `last_grant`:
  - `hold`=1: both ready signals are 0.
  - Exactly one valid: that requester gets ready=1.
  - Both valid: the requester with index != `last_grant` gets ready=1. The other gets 0.
  - At most one ready is high in any cycle.
- On accept:
  - Output registers load the granted rg/data.
  - The RegWrite register loads 1.
  - `last_grant` loads the granted index.
- With no accept, the RegWrite register loads 0. `WriteRg`/`WriteData` keep their last value.
- Requester rule: once `reqN_valid` is raised, rg/data must stay stable until accepted. The arbiter has no internal buffering beyond the single output stage.
- `wr_count` increments on every cycle in which `RegWrite` is 1, and wraps from all-ones to 0.
- Reset values:
  - `WriteRg`=0, `WriteData`=0, `RegWrite`=0, `wr_count`=0.
  - `last_grant`=1, so requester 0 wins the first tie.

## Timing
- Latency: a beat accepted at edge N gives `RegWrite`=1 with its rg/data during the cycle following edge N. `RegWrite` drops at edge N+1 unless another beat is accepted at N+1.
- Throughput: one write per cycle.
- Fairness: with both requesters continuously valid and `hold`=0, grants alternate 0,1,0,1…
- `hold` rising while a beat is already registered: that beat still pulses `RegWrite` once. Only new grants are blocked.
- `hold` and valids may change in any cycle. Ready follows combinationally.
- Reset asserted mid-operation: all outputs clear immediately, without waiting for `clk`. An in-flight beat is lost. Requesters must re-present after reset deasserts.
- Identical rg from both requesters in consecutive grants: both writes are issued in grant order, and the later value wins in the bank.

## Configuration
- `BANCO_ZERO_GUARD_EN`:
  - Defined: an accepted beat with rg=0 is consumed (ready=1, `last_grant` updates), but `RegWrite` stays 0 for it and `wr_count` does not increment. `WriteRg`/`WriteData` are not updated. Register 0 is never written.
  - Undefined: rg=0 beats are written like any other register.

## Test plan
- Reset, then idle:
  - Outputs: `RegWrite`=0, `wr_count`=0, `last_grant`=1, `WriteRg`=0, `WriteData`=0.
  - Raise `req0_valid` with rg=5, data=0x12345678: `req0_ready`=1, then `RegWrite`=1, `WriteRg`=5, `WriteData`=0x12345678 for exactly one cycle; `wr_count`=1.
- Both valid for 4 cycles (req0 rg=1 data=0xA, req1 rg=2 data=0xB; requesters advance after each accept):
  - Grants go 0,1,0,1; `RegWrite` is high 4 consecutive cycles; `wr_count`=4.
- `hold`=1 for 3 cycles with both valid:
  - Both ready=0 and no new pulses.
  - A beat accepted the cycle before `hold` rose still pulses once.
- req0 valid with rg=0, data=0xFFFFFFFF:
  - With `BANCO_ZERO_GUARD_EN`: accepted, `RegWrite` stays 0, `wr_count` unchanged.
  - Without it: one pulse with `WriteRg`=0.
- Assert `rst` between edges in the cycle `RegWrite`=1: `RegWrite` falls before the next edge and `wr_count`=0.
- `CNT_W`=4 with 17 accepted writes: `wr_count` wraps to 1.
